// File: rtl/complex_to_pixel.sv
// Maps a Q4.20 complex point plus pan offsets to saturated screen pixel coordinates and an in-view flag.
// Two register stages (offset/bias subtract, then scale/saturate); stalls propagate back through in_ready.
module complex_to_pixel #(
   parameter int PIXEL_DATA_WIDTH   = 10,
   parameter int ENGINE_DATA_WIDTH  = 25,
   parameter int ENGINE_FRACT_WIDTH = 20,
   parameter int H_RES              = 640,
   parameter int V_RES              = 480,
   parameter int TAG_WIDTH          = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] real_x,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] imag_y,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
   input  logic [TAG_WIDTH-1:0]                tag_in,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [PIXEL_DATA_WIDTH-1:0]         pixel_x_out,
   output logic [PIXEL_DATA_WIDTH-1:0]         pixel_y_out,
   output logic                                in_view,
   output logic [TAG_WIDTH-1:0]                tag_out
);

   localparam int DW = ENGINE_DATA_WIDTH + 2;
   localparam int PW = DW + 8;
   localparam int QW = PW - ENGINE_FRACT_WIDTH;
   localparam logic signed [DW-1:0] X_BIAS = DW'(2 << ENGINE_FRACT_WIDTH);
   localparam logic signed [DW-1:0] Y_BIAS = DW'(3 << (ENGINE_FRACT_WIDTH - 1));

   // Multiply by 160 (= 128 + 32) and floor back to integer pixels.
   function automatic logic signed [QW-1:0] scale(input logic signed [DW-1:0] d);
      logic signed [PW-1:0] e;
      logic signed [PW-1:0] p;
      e = PW'(d);
      p = (e <<< 7) + (e <<< 5);
      return signed'(p[PW-1:ENGINE_FRACT_WIDTH]);
   endfunction

   function automatic logic on_axis(input logic signed [QW-1:0] v, input int lim);
      return !v[QW-1] && (v < QW'(lim));
   endfunction

   function automatic logic [PIXEL_DATA_WIDTH-1:0] clamp(input logic signed [QW-1:0] v, input int lim);
      if (v[QW-1]) return '0;
      if (v >= QW'(lim)) return PIXEL_DATA_WIDTH'(lim - 1);
      return v[PIXEL_DATA_WIDTH-1:0];
   endfunction

   logic                        s1_valid_q, s1_valid_d;
   logic signed [DW-1:0]        dx_q, dx_d;
   logic signed [DW-1:0]        dy_q, dy_d;
   logic [TAG_WIDTH-1:0]        s1_tag_q, s1_tag_d;
   logic                        s2_valid_q, s2_valid_d;
   logic [PIXEL_DATA_WIDTH-1:0] px_q, px_d;
   logic [PIXEL_DATA_WIDTH-1:0] py_q, py_d;
   logic                        view_q, view_d;
   logic [TAG_WIDTH-1:0]        s2_tag_q, s2_tag_d;
   logic                        s1_advance;
   logic                        accept;
   logic signed [QW-1:0]        px;
   logic signed [QW-1:0]        py;

   always_comb begin
      s1_advance = !s2_valid_q || out_ready;
      in_ready   = !s1_valid_q || s1_advance;
      accept     = in_valid && in_ready;

      s1_valid_d = in_ready ? in_valid : s1_valid_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      s1_tag_d   = s1_tag_q;
      // Offsets are folded in here so later pan changes cannot touch this item.
      if (accept) begin
         dx_d     = DW'(real_x) - DW'(x_offset) + X_BIAS;
         dy_d     = DW'(imag_y) - DW'(y_offset) + Y_BIAS;
         s1_tag_d = tag_in;
      end

      px         = scale(dx_q);
      py         = scale(dy_q);
      s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
      px_d       = px_q;
      py_d       = py_q;
      view_d     = view_q;
      s2_tag_d   = s2_tag_q;
      if (s1_advance && s1_valid_q) begin
         px_d     = clamp(px, H_RES);
         py_d     = clamp(py, V_RES);
         view_d   = on_axis(px, H_RES) && on_axis(py, V_RES);
         s2_tag_d = s1_tag_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         dx_q       <= '0;
         dy_q       <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         px_q       <= '0;
         py_q       <= '0;
         view_q     <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         px_q       <= px_d;
         py_q       <= py_d;
         view_q     <= view_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign pixel_x_out = px_q;
   assign pixel_y_out = py_q;
   assign in_view     = view_q;
   assign tag_out     = s2_tag_q;

endmodule

// File: tb/tb_complex_to_pixel.sv
// Bench for complex_to_pixel: directed plan items plus randomized traffic against a floor-division model.
module tb_complex_to_pixel;
   localparam int EDW = 25;
   localparam longint ONE = 1 << 20;
   localparam longint STEP = 6554;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, in_view;
   logic [24:0] real_x, imag_y, x_offset, y_offset;
   logic [7:0]  tag_in, tag_out;
   logic [9:0]  pixel_x_out, pixel_y_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct { int px; int py; bit v; logic [7:0] tag; } exp_t;
   exp_t sbq[$];
   int   rt_x_q[$];
   int   rt_y_q[$];
   logic [7:0] out_log[$];
   bit   hold_pend = 0;
   logic [9:0] hx, hy;
   logic hv;
   logic [7:0] ht;

   always #5 clk = ~clk;

   complex_to_pixel dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .real_x(real_x), .imag_y(imag_y), .x_offset(x_offset), .y_offset(y_offset),
      .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
      .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out), .in_view(in_view), .tag_out(tag_out)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q--;
      return q;
   endfunction

   function automatic exp_t model(input longint rx, input longint ry, input longint xo,
                                  input longint yo, input logic [7:0] tg);
      exp_t e;
      longint fx, fy;
      fx = fdiv((rx - xo + 2 * ONE) * 160, ONE);
      fy = fdiv((ry - yo + 3 * ONE / 2) * 160, ONE);
      e.v   = (fx >= 0 && fx < 640 && fy >= 0 && fy < 480);
      e.px  = (fx < 0) ? 0 : (fx > 639) ? 639 : int'(fx);
      e.py  = (fy < 0) ? 0 : (fy > 479) ? 479 : int'(fy);
      e.tag = tg;
      return e;
   endfunction

   // Scoreboard: record accepted inputs, check every delivered output and stall stability.
   always @(negedge clk) begin
      if (reset) begin
         sbq.delete();
         hold_pend = 0;
      end else begin
         if (in_valid && in_ready)
            sbq.push_back(model(longint'($signed(real_x)), longint'($signed(imag_y)),
                                longint'($signed(x_offset)), longint'($signed(y_offset)), tag_in));
         if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_x", pixel_x_out, hx);
            chk("hold_y", pixel_y_out, hy);
            chk("hold_view", in_view, hv);
            chk("hold_tag", tag_out, ht);
            hold_pend = 0;
         end
         if (out_valid && !out_ready) begin
            hold_pend = 1;
            hx = pixel_x_out; hy = pixel_y_out; hv = in_view; ht = tag_out;
         end
         if (out_valid && out_ready) begin
            out_log.push_back(tag_out);
            if (sbq.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_x", pixel_x_out, e.px);
               chk("sb_y", pixel_y_out, e.py);
               chk("sb_view", in_view, e.v);
               chk("sb_tag", tag_out, e.tag);
            end
            if (rt_x_q.size() > 0) begin
               chk("roundtrip_x", pixel_x_out, rt_x_q.pop_front());
               chk("roundtrip_y", pixel_y_out, rt_y_q.pop_front());
            end
         end
      end
   end

   task automatic set_in(input longint rx, input longint ry, input longint xo,
                         input longint yo, input logic [7:0] tg);
      real_x = EDW'(rx); imag_y = EDW'(ry);
      x_offset = EDW'(xo); y_offset = EDW'(yo);
      tag_in = tg;
      in_valid = 1'b1;
   endtask

   task automatic send(input longint rx, input longint ry, input longint xo,
                       input longint yo, input logic [7:0] tg);
      int  n;
      bit  acc;
      set_in(rx, ry, xo, yo, tg);
      n = 0; acc = 0;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic get_out(output logic [9:0] gx, output logic [9:0] gy, output logic gv,
                          output logic [7:0] gt, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 50);
      if (!out_valid) chk("out_timeout", 0, 1);
      gx = pixel_x_out; gy = pixel_y_out; gv = in_view; gt = tag_out;
      @(posedge clk); #1;
   endtask

   task automatic expect_item(input string nm, input longint rx, input longint ry,
                              input longint xo, input longint yo, input logic [7:0] tg,
                              input int ex, input int ey, input bit ev);
      logic [9:0] gx, gy;
      logic gv;
      logic [7:0] gt;
      int lat;
      send(rx, ry, xo, yo, tg);
      get_out(gx, gy, gv, gt, lat);
      chk({nm, "_lat"}, lat, 2);
      chk({nm, "_x"}, gx, ex);
      chk({nm, "_y"}, gy, ey);
      chk({nm, "_view"}, gv, ev);
      chk({nm, "_tag"}, gt, tg);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sbq.size() != 0) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sbq.size(), 0);
   endtask

   function automatic longint rnd_coord(input longint base);
      if ($urandom_range(0, 1) == 1)
         return longint'($urandom_range(0, (1 << 25) - 1)) - (1 << 24);
      return base + (longint'($urandom_range(0, 900)) - 100) * STEP + longint'($urandom_range(0, 6553));
   endfunction

   function automatic longint rnd_off();
      if ($urandom_range(0, 3) == 0)
         return longint'($urandom_range(0, 2 * (1 << 20))) - (1 << 20);
      return 0;
   endfunction

   initial begin
      logic [9:0] gx, gy;
      logic gv;
      logic [7:0] gt;
      int lat;
      bit rand_run;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      real_x = '0; imag_y = '0; x_offset = '0; y_offset = '0; tag_in = '0;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_px", pixel_x_out, 0);
      chk("rst_py", pixel_y_out, 0);
      chk("rst_view", in_view, 0);
      chk("rst_tag", tag_out, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1 chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      expect_item("origin", -2 * ONE, -3 * ONE / 2, 0, 0, 8'h11, 0, 0, 1);
      expect_item("corner", 2090854, 1566502, 0, 0, 8'h22, 639, 479, 1);
      expect_item("right_edge", 2 * ONE, 0, 0, 0, 8'h33, 639, 240, 0);
      expect_item("left_out", -5 * ONE / 2, 0, 0, 0, 8'h44, 0, 240, 0);
      expect_item("pan", ONE, 0, ONE, 0, 8'h55, 320, 240, 1);

      // Pan offset changes while the item sits in stage 1.
      send(ONE, 0, ONE, 0, 8'h66);
      x_offset = EDW'(3 * ONE);
      get_out(gx, gy, gv, gt, lat);
      chk("pan_change_x", gx, 320);
      chk("pan_change_view", gv, 1);
      x_offset = '0;

      for (int p = 0; p < 640; p++) begin
         rt_x_q.push_back(p);
         rt_y_q.push_back(p % 480);
         send(-2 * ONE + p * STEP, -3 * ONE / 2 + (p % 480) * STEP, 0, 0, 8'(p));
      end
      wait_drain();
      chk("roundtrip_left", rt_x_q.size(), 0);

      out_ready = 1'b0;
      out_log.delete();
      set_in(0, 0, 0, 0, 8'hA1);
      @(negedge clk); chk("bp_rdy_a", in_ready, 1);
      @(posedge clk); #1;
      set_in(ONE, 0, 0, 0, 8'hA2);
      @(negedge clk); chk("bp_rdy_b", in_ready, 1);
      @(posedge clk); #1;
      set_in(-ONE, ONE, 0, 0, 8'hA3);
      repeat (3) begin
         @(negedge clk); chk("bp_rdy_c", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk); chk("bp_rdy_rel", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();
      chk("bp_count", out_log.size(), 3);
      if (out_log.size() == 3) begin
         chk("bp_tag0", out_log[0], 8'hA1);
         chk("bp_tag1", out_log[1], 8'hA2);
         chk("bp_tag2", out_log[2], 8'hA3);
      end

      out_ready = 1'b0;
      send(0, 0, 0, 0, 8'hB1);
      send(ONE, 0, 0, 0, 8'hB2);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_px", pixel_x_out, 0);
      chk("mid_rst_py", pixel_y_out, 0);
      chk("mid_rst_view", in_view, 0);
      chk("mid_rst_tag", tag_out, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_log.delete();
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("flushed", out_log.size(), 0);
      expect_item("post_rst", 0, 0, 0, 0, 8'hC1, 320, 240, 1);
      chk("post_rst_count", out_log.size(), 1);

      rand_run = 1;
      fork
         begin
            while (rand_run) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int i = 0; i < 1500; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send(rnd_coord(-2 * ONE), rnd_coord(-3 * ONE / 2), rnd_off(), rnd_off(),
                    8'($urandom_range(0, 255)));
            end
            rand_run = 0;
         end
      join
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end
endmodule
